branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
Dynamic branch predictor for the RV32I 3-stage pipeline. In IF it looks up the fetch PC and supplies the predicted next PC. In EX it consumes the resolved branch outcome (taken flag and target from the branch comparator and adder), trains its tables, and flags mispredictions so the pipeline can flush and redirect. It is a direct-mapped branch target buffer with a 2-bit saturating counter per entry.

Parameters:
IDX_W, 4, index width; table holds 2**IDX_W entries indexed by pc[IDX_W+1:2].
TAG_W, 26, tag width = 32-2-IDX_W; tag is pc[31:IDX_W+2]. Must satisfy TAG_W+IDX_W == 30.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
if_pc  in  32  fetch PC to predict
pred_hit  out  1  valid entry with matching tag at if_pc index
pred_taken  out  1  pred_hit && counter[1]
pred_npc  out  32  pred_taken ? stored target : if_pc+4
ex_valid  in  1  EX holds a resolved conditional branch this cycle
ex_pc  in  32  PC of the resolving branch
ex_taken  in  1  actual outcome (branch comparator result)
ex_target  in  32  computed branch target
ex_pred_taken  in  1  pred_taken carried down the pipe with this branch
ex_pred_npc  in  32  pred_npc carried down the pipe with this branch
mispredict  out  1  flush request
redirect_pc  out  32  correct next PC when mispredict=1
br_count  out  32  resolved-branch counter
mispred_count  out  32  mispredict counter

Behaviour:
- Entry fields: valid(1), tag(TAG_W), target(32), ctr(2).
- Reset (rst_n=0 at clk edge): all valid=0, all ctr=2'b01, br_count=0, mispred_count=0. Target and tag values are don't-care. Reset mid-operation discards all training. No update occurs on a reset cycle even if ex_valid=1.
- Lookup is combinational from if_pc against registered table state, with zero-cycle latency. On a miss: pred_hit=0, pred_taken=0, pred_npc=if_pc+4.
- Correct next PC: actual_npc = ex_taken ? ex_target : ex_pc+4 (32-bit add, wraps modulo 2**32).
- mispredict is combinational: ex_valid && (actual_npc != ex_pred_npc). This covers direction errors and wrong targets. redirect_pc = actual_npc at all times. When ex_valid=0, mispredict=0.
- Update on a clk edge with ex_valid=1 and rst_n=1, at index ex_pc[IDX_W+1:2]:
  * Hit, taken: ctr = min(ctr+1, 3); target = ex_target.
  * Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  * Miss, taken: allocate by overwriting any occupant. valid=1, tag=ex_pc tag, target=ex_target, ctr=2'b10.
  * Miss, not taken: table unchanged (no allocation).
- Counters: br_count += 1 per update cycle; mispred_count += 1 when mispredict=1. Both wrap at 2**32.
- Simultaneous IF lookup and EX update to the same index: the lookup sees pre-update state. The new state is visible from the next cycle.
- Aliasing: an entry whose tag differs is a miss. It is never partially matched.
- ex_pc[1:0] and if_pc[1:0] are ignored.

Test Plan:
- Reset, then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_npc=0x104. br_count=0 and mispred_count=0.
- EX update ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_npc=0x104 -> mispredict=1 and redirect_pc=0x80 that cycle. Next cycle if_pc=0x100 gives pred_hit=1, pred_taken=1, pred_npc=0x80. mispred_count=1.
- Train 0x100 taken twice more (ctr=3), then not-taken once -> ctr=2, prediction still taken to 0x80. Second not-taken -> ctr=1, pred_npc=0x104, pred_hit=1. Two further not-takens -> ctr stays 0.
- Correct direction, wrong target: entry target 0x80, ex_taken=1, ex_target=0x90, ex_pred_npc=0x80 -> mispredict=1, redirect_pc=0x90. Entry target becomes 0x90.
- Alias with IDX_W=4: allocate 0x100 taken, then update 0x140 taken -> 0x140 entry replaces it. if_pc=0x100 misses (pred_npc=0x104). A not-taken miss at 0x200 leaves the table unchanged.
- Same-cycle lookup and update on if_pc=ex_pc=0x300, first taken -> that cycle pred_hit=0. Next cycle pred_hit=1. Assert rst_n=0 with ex_valid=1 -> no allocation, all predictions miss afterward, both counters return to 0.

Source files
------------

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-side lookup and execute-side resolve signals of the branch predictor.
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_npc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;
  modport master (
    output if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_npc,
    input  pred_hit, pred_taken, pred_npc, mispredict, redirect_pc, br_count, mispred_count
  );
  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_npc,
    output pred_hit, pred_taken, pred_npc, mispredict, redirect_pc, br_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters, lookup in IF, training in EX.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input logic          clk,
  input logic          rst_n,
  branch_predictor_if.slave bp
);
  localparam int N = 1 << IDX_W;
  logic              r_valid  [N];
  logic [TAG_W-1:0]  r_tag    [N];
  logic [31:0]       r_target [N];
  logic [1:0]        r_ctr    [N];
  logic [31:0]       r_br_count;
  logic [31:0]       r_mispred_count;
  logic [IDX_W-1:0]  w_if_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic [TAG_W-1:0]  w_if_tag;
  logic [TAG_W-1:0]  w_ex_tag;
  logic              w_if_hit;
  logic              w_ex_hit;
  logic              w_pred_taken;
  logic              w_mispredict;
  logic [31:0]       w_actual_npc;
  logic [1:0]        w_ctr;
  logic [1:0]        w_ctr_nxt;
  logic              w_unused;
  assign w_if_idx     = bp.if_pc[IDX_W+1:2];
  assign w_if_tag     = bp.if_pc[31:IDX_W+2];
  assign w_ex_idx     = bp.ex_pc[IDX_W+1:2];
  assign w_ex_tag     = bp.ex_pc[31:IDX_W+2];
  assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_pred_taken = w_if_hit && r_ctr[w_if_idx][1];
  assign w_actual_npc = bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;
  assign w_mispredict = bp.ex_valid && (w_actual_npc != bp.ex_pred_npc);
  assign w_ctr        = r_ctr[w_ex_idx];
  assign w_ctr_nxt    = bp.ex_taken ? (w_ctr == 2'd3 ? w_ctr : w_ctr + 2'd1)
                                    : (w_ctr == 2'd0 ? w_ctr : w_ctr - 2'd1);
  // Direction is judged purely by next-PC comparison, so wrong targets flush too.
  assign w_unused          = &{1'b0, bp.ex_pred_taken, bp.if_pc[1:0], bp.ex_pc[1:0]};
  assign bp.pred_hit       = w_if_hit;
  assign bp.pred_taken     = w_pred_taken;
  assign bp.pred_npc       = w_pred_taken ? r_target[w_if_idx] : bp.if_pc + 32'd4;
  assign bp.mispredict     = w_mispredict;
  assign bp.redirect_pc    = w_actual_npc;
  assign bp.br_count       = r_br_count;
  assign bp.mispred_count  = r_mispred_count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (bp.ex_valid) begin
      r_br_count      <= r_br_count + 32'd1;
      r_mispred_count <= r_mispred_count + {31'd0, w_mispredict};
      if (w_ex_hit) begin
        r_ctr[w_ex_idx] <= w_ctr_nxt;
        if (bp.ex_taken) r_target[w_ex_idx] <= bp.ex_target;
      end else if (bp.ex_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= bp.ex_target;
        r_ctr[w_ex_idx]    <= 2'b10;
      end
    end
  end
endmodule
